// File: rtl/sort_result_serializer_if.sv
// Valid/ready stream carrying one sorted element per beat, with an end-of-frame marker.
interface sort_result_serializer_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;
  logic             last;

  modport master (output data, output valid, output last, input ready);
  modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/sort_result_serializer.sv
// Captures a 4-element sorted set on the rising edge of the sorter's done and
// streams it one element per beat, flagging results that arrive mid-frame and
// counting completed frames.
module sort_result_serializer #(
  parameter int WIDTH  = 4,
  parameter bit ASCEND = 1'b1,
  parameter int CNT_W  = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      done_i,
  input  logic [WIDTH-1:0]          s0_i,
  input  logic [WIDTH-1:0]          s1_i,
  input  logic [WIDTH-1:0]          s2_i,
  input  logic [WIDTH-1:0]          s3_i,
  sort_result_serializer_if.master  out_if,
  output logic                      busy_o,
  output logic                      overrun_o,
  output logic [CNT_W-1:0]          frame_cnt_o
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic                    done_q;
  logic [1:0]              idx_q, idx_d;
  logic [3:0][WIDTH-1:0]   buf_q, buf_d;
  logic                    overrun_q, overrun_d;
  logic [CNT_W-1:0]        frameCnt_q, frameCnt_d;

  logic                    rise;
  logic                    transfer;
  logic                    lastTransfer;
  logic                    capture;

  assign rise         = done_i & ~done_q;
  assign transfer     = (state_q == SEND) & out_if.ready;
  assign lastTransfer = transfer & (idx_q == 2'd3);

  // State and datapath registers; reset discards any frame in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      done_q     <= 1'b0;
      idx_q      <= 2'd0;
      buf_q      <= '0;
      overrun_q  <= 1'b0;
      frameCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      done_q     <= done_i;
      idx_q      <= idx_d;
      buf_q      <= buf_d;
      overrun_q  <= overrun_d;
      frameCnt_q <= frameCnt_d;
    end
  end

  // Next-state logic: capture on a done rise when free (idle or on the final
  // beat), advance the index on each accepted beat, and drop any other rise.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    buf_d      = buf_q;
    frameCnt_d = frameCnt_q;
    overrun_d  = 1'b0;
    capture    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rise) begin
          capture = 1'b1;
          idx_d   = 2'd0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (transfer) begin
          if (idx_q != 2'd3) begin
            idx_d = idx_q + 2'd1;
          end else begin
            frameCnt_d = frameCnt_q + CNT_W'(1);
            idx_d      = 2'd0;
            if (rise) begin
              capture = 1'b1;
              state_d = SEND;
            end else begin
              state_d = IDLE;
            end
          end
        end
        if (rise && !lastTransfer) begin
          overrun_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (capture) begin
      if (ASCEND) begin
        buf_d = {s3_i, s2_i, s1_i, s0_i};
      end else begin
        buf_d = {s0_i, s1_i, s2_i, s3_i};
      end
    end
  end

  // Output logic: everything is driven from registered state only, so the
  // beat stays stable while the consumer stalls.
  always_comb begin
    out_if.valid = (state_q == SEND);
    out_if.data  = (state_q == SEND) ? buf_q[idx_q] : '0;
    out_if.last  = (state_q == SEND) && (idx_q == 2'd3);
    busy_o       = (state_q == SEND);
    overrun_o    = overrun_q;
    frame_cnt_o  = frameCnt_q;
  end

endmodule

// File: tb/tb_sort_result_serializer.sv
// Self-checking bench: an ascending and a descending instance share stimulus
// and are compared every cycle against a queue-based model of the stream.
module tb_sort_result_serializer;

  localparam int W  = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          done = 1'b0;
  logic          ready = 1'b0;
  logic [W-1:0]  s0 = '0, s1 = '0, s2 = '0, s3 = '0;

  logic          busyA, overrunA, busyD, overrunD;
  logic [CW-1:0] frameA, frameD;

  int checks = 0;
  int failures = 0;

  // Expected beats still to be delivered; a = ascending instance, d = descending.
  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] d;
  } beat_t;

  beat_t pend[$];
  int    expFrames = 0;
  bit    expOverrun = 1'b0;
  bit    prevDone = 1'b0;

  always #5 clk = ~clk;

  sort_result_serializer_if #(.WIDTH(W)) busA ();
  sort_result_serializer_if #(.WIDTH(W)) busD ();

  assign busA.ready = ready;
  assign busD.ready = ready;

  sort_result_serializer #(.WIDTH(W), .ASCEND(1'b1), .CNT_W(CW)) dutA (
    .clk_i(clk), .rst_ni(rst_n), .done_i(done),
    .s0_i(s0), .s1_i(s1), .s2_i(s2), .s3_i(s3),
    .out_if(busA), .busy_o(busyA), .overrun_o(overrunA), .frame_cnt_o(frameA)
  );

  sort_result_serializer #(.WIDTH(W), .ASCEND(1'b0), .CNT_W(CW)) dutD (
    .clk_i(clk), .rst_ni(rst_n), .done_i(done),
    .s0_i(s0), .s1_i(s1), .s2_i(s2), .s3_i(s3),
    .out_if(busD), .busy_o(busyD), .overrun_o(overrunD), .frame_cnt_o(frameD)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  // Compare both instances against the model's view of the current cycle.
  task automatic compareAll();
    logic expV;
    logic expL;
    expV = (pend.size() > 0);
    expL = (pend.size() == 1);
    checkOutput("validA", 32'(busA.valid), 32'(expV));
    checkOutput("validD", 32'(busD.valid), 32'(expV));
    checkOutput("busyA", 32'(busyA), 32'(expV));
    checkOutput("busyD", 32'(busyD), 32'(expV));
    checkOutput("lastA", 32'(busA.last), 32'(expL));
    checkOutput("lastD", 32'(busD.last), 32'(expL));
    checkOutput("overrunA", 32'(overrunA), 32'(expOverrun));
    checkOutput("overrunD", 32'(overrunD), 32'(expOverrun));
    checkOutput("framesA", 32'(frameA), 32'(expFrames & 255));
    checkOutput("framesD", 32'(frameD), 32'(expFrames & 255));
    if (expV) begin
      checkOutput("dataA", 32'(busA.data), 32'(pend[0].a));
      checkOutput("dataD", 32'(busD.data), 32'(pend[0].d));
    end
  endtask

  // Drive one cycle of inputs, check current outputs, advance the model and the clock.
  task automatic applyStimulus(input bit d, input logic [W-1:0] v0, input logic [W-1:0] v1,
                               input logic [W-1:0] v2, input logic [W-1:0] v3, input bit r);
    logic [W-1:0] vals [4];
    bit rise;
    done  = d;
    s0 = v0; s1 = v1; s2 = v2; s3 = v3;
    ready = r;
    vals[0] = v0; vals[1] = v1; vals[2] = v2; vals[3] = v3;
    compareAll();
    rise = d && !prevDone;
    expOverrun = 1'b0;
    if (r && pend.size() > 0) begin
      void'(pend.pop_front());
      if (pend.size() == 0) expFrames++;
    end
    if (rise) begin
      if (pend.size() == 0) begin
        for (int i = 0; i < 4; i++) pend.push_back('{a: vals[i], d: vals[3-i]});
      end else begin
        expOverrun = 1'b1;
      end
    end
    prevDone = d;
    @(posedge clk);
    #1;
  endtask

  // Assert reset away from the clock edge, check outputs drop at once, then release.
  task automatic doReset(input bit holdDone);
    done = holdDone;
    rst_n = 1'b0;
    pend.delete();
    expFrames = 0;
    expOverrun = 1'b0;
    prevDone = 1'b0;
    #1;
    compareAll();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      compareAll();
    end
    #2;
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    int framesBefore;
    bit rd;

    @(posedge clk);
    #1;
    doReset(1'b0);

    // Basic frame with continuous ready: 1,2,4,8 ascending, 8,4,2,1 descending.
    applyStimulus(0, 1, 2, 4, 8, 1);
    applyStimulus(1, 1, 2, 4, 8, 1);
    checkOutput("t1_firstA", 32'(busA.data), 32'd1);
    checkOutput("t1_firstD", 32'(busD.data), 32'd8);
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, 2, 4, 8, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("t1_frames", 32'(frameA), 32'd1);

    // Backpressure at idx=1: data holds while ready is low.
    applyStimulus(1, 1, 2, 4, 8, 1);
    applyStimulus(0, 9, 9, 9, 9, 1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 9, 9, 9, 9, 0);
      checkOutput("t3_holdA", 32'(busA.data), 32'd2);
    end
    for (int i = 0; i < 4; i++) applyStimulus(0, 9, 9, 9, 9, 1);
    checkOutput("t3_frames", 32'(frameA), 32'd2);

    // Overrun: a rise at idx=1 is dropped and the frame completes unchanged.
    applyStimulus(1, 1, 2, 4, 8, 1);
    applyStimulus(0, 1, 2, 4, 8, 1);
    applyStimulus(1, 3, 5, 7, 9, 1);
    checkOutput("t4_overrun", 32'(overrunA), 32'd1);
    for (int i = 0; i < 4; i++) applyStimulus(1, 3, 5, 7, 9, 1);
    checkOutput("t4_idle", 32'(busA.valid), 32'd0);
    checkOutput("t4_frames", 32'(frameA), 32'd3);
    applyStimulus(0, 0, 0, 0, 0, 1);

    // Back-to-back: a rise on the final beat starts the next frame with no gap.
    applyStimulus(1, 1, 2, 4, 8, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 2, 4, 8, 1);
    applyStimulus(1, 3, 5, 7, 9, 1);
    checkOutput("t5_nextA", 32'(busA.data), 32'd3);
    checkOutput("t5_validA", 32'(busA.valid), 32'd1);
    for (int i = 0; i < 4; i++) applyStimulus(1, 3, 5, 7, 9, 1);
    checkOutput("t5_frames", 32'(frameA), 32'd5);

    // Reset mid-frame at idx=2, with done held high across release.
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(1, 1, 2, 4, 8, 1);
    applyStimulus(1, 1, 2, 4, 8, 1);
    applyStimulus(1, 1, 2, 4, 8, 1);
    checkOutput("t6_idx2A", 32'(busA.data), 32'd4);
    doReset(1'b1);
    checkOutput("t6_validA", 32'(busA.valid), 32'd0);
    checkOutput("t6_frames", 32'(frameA), 32'd0);
    for (int i = 0; i < 6; i++) applyStimulus(1, 6, 7, 10, 12, 1);
    checkOutput("t6_newframe", 32'(frameA), 32'd1);

    // Randomized traffic with occasional resets.
    rd = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (c % 700 == 699) doReset(1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) rd = ~rd;
      applyStimulus(rd, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                    ($urandom_range(0, 3) != 0));
    end

    // Drain any frame still in flight.
    framesBefore = expFrames;
    for (int i = 0; i < 8; i++) applyStimulus(rd, 0, 0, 0, 0, 1);
    checkOutput("drain_idle", 32'(busA.valid), 32'd0);
    if (framesBefore < 0) $display("[TB] negative frame count");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
